// File: rtl/result_serializer.sv
// Latches the compressor's concatenated result columns and shifts them out LSB-first
// over a valid/ready serial pin. Optional capture MISR enabled by RESULT_SIGNATURE_EN.
module result_serializer #(
    parameter int NDST      = 27,
    parameter int DST_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NDST*DST_WIDTH-1:0] dst_bus,
    input  logic                      capture,
    output logic                      sout,
    output logic                      sout_valid,
    input  logic                      sout_ready,
    output logic                      sout_last,
    output logic                      busy,
    output logic                      done,
    output logic                      capture_drop,
    output logic [31:0]               signature
);

    localparam int TOTAL = NDST * DST_WIDTH;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TOTAL-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             cap_accept;

    assign cap_accept = (state_q == S_IDLE) && capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    shreg_d = dst_bus;
                    count_d = CNT_W'(TOTAL);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (capture) begin
                    drop_d = 1'b1;
                end
                // Advance only on a completed handshake so a stalled bit is held, never skipped.
                if (sout_ready) begin
                    shreg_d = shreg_q >> 1;
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (capture) begin
                    drop_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sout_valid   = (state_q == S_SHIFT);
    assign sout         = sout_valid & shreg_q[0];
    assign sout_last    = sout_valid && (count_q == CNT_W'(1));
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign capture_drop = drop_q;

`ifdef RESULT_SIGNATURE_EN
    localparam int NCHUNK = (TOTAL + 31) / 32;

    logic [NCHUNK*32-1:0] pad_bus;
    logic [31:0]          fold;
    logic [31:0]          sig_q, sig_d;

    assign pad_bus = (NCHUNK*32)'(dst_bus);

    always_comb begin
        fold = 32'h0;
        for (int k = 0; k < NCHUNK; k++) begin
            fold = fold ^ pad_bus[k*32 +: 32];
        end
    end

    // CRC-32 polynomial feedback folded with the captured word.
    always_comb begin
        sig_d = sig_q;
        if (cap_accept) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 32'h0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    logic unused_accept;
    assign unused_accept = cap_accept;
    assign signature     = 32'h0;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: directed scenarios plus randomized words and
// ready patterns, compared against a bit-list / arithmetic-MISR reference model.
module tb_result_serializer;

    localparam int NDST  = 27;
    localparam int DSTW  = 1;
    localparam int TOTAL = NDST * DSTW;

    logic             clk = 1'b0;
    logic             rst;
    logic [TOTAL-1:0] dst_bus;
    logic             capture;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             busy;
    logic             done;
    logic             capture_drop;
    logic [31:0]      signature;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_sig  = 32'h0;
    logic        exp_drop = 1'b0;

    always #5 clk = ~clk;

    result_serializer #(.NDST(NDST), .DST_WIDTH(DSTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dst_bus      (dst_bus),
        .capture      (capture),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .sout_ready   (sout_ready),
        .sout_last    (sout_last),
        .busy         (busy),
        .done         (done),
        .capture_drop (capture_drop),
        .signature    (signature)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference MISR: shift with polynomial feedback, then XOR each word bit into position b mod 32.
    function automatic logic [31:0] model_sig(input logic [31:0] s, input logic [TOTAL-1:0] w);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ 32'h04C11DB7;
        for (int b = 0; b < TOTAL; b++) begin
            r[b % 32] = r[b % 32] ^ w[b];
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, ".valid"}, 32'(sout_valid), 32'h0);
        check_eq({tag, ".sout"},  32'(sout), 32'h0);
        check_eq({tag, ".last"},  32'(sout_last), 32'h0);
        check_eq({tag, ".busy"},  32'(busy), 32'h0);
        check_eq({tag, ".done"},  32'(done), 32'h0);
        check_eq({tag, ".drop"},  32'(capture_drop), 32'(exp_drop));
        check_eq({tag, ".sig"},   signature, exp_sig);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_drop = 1'b0;
        exp_sig  = 32'h0;
        check_idle("reset");
    endtask

    task automatic capture_word(input logic [TOTAL-1:0] w);
        dst_bus = w;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
`ifdef RESULT_SIGNATURE_EN
        exp_sig = model_sig(exp_sig, w);
`endif
        check_eq("cap.sig", signature, exp_sig);
    endtask

    // Streams the word just captured; optional stall window, drop injection, mid-word reset
    // and a capture during the DONE cycle.
    task automatic stream_word(input logic [TOTAL-1:0] w, input int ready_pct,
                               input int stall_at, input int stall_len, input int drop_at,
                               input int abort_at, input bit drop_in_done);
        int  i = 0;
        int  stalls = 0;
        int  cyc = 0;
        bit  dropped = 1'b0;
        logic rdy;
        while (i < TOTAL) begin
            if (cyc > 400) begin
                check_eq("stream.timeout", 32'(cyc), 32'(TOTAL));
                return;
            end
            check_eq("bit.valid", 32'(sout_valid), 32'h1);
            check_eq($sformatf("bit%0d.sout", i), 32'(sout), 32'(w[i]));
            check_eq("bit.last", 32'(sout_last), 32'(i == TOTAL - 1));
            check_eq("bit.busy", 32'(busy), 32'h1);
            check_eq("bit.done", 32'(done), 32'h0);
            check_eq("bit.drop", 32'(capture_drop), 32'(exp_drop));
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_drop = 1'b0;
                exp_sig  = 32'h0;
                check_idle("abort");
                $display("word %h aborted at bit %0d", w, i);
                return;
            end
            rdy = ($urandom_range(99) < 32'(ready_pct));
            if (i == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            sout_ready = rdy;
            if (i == drop_at && !dropped) begin
                capture  = 1'b1;
                dst_bus  = TOTAL'($urandom) | TOTAL'(1);
                dropped  = 1'b1;
                exp_drop = 1'b1;
            end
            @(negedge clk);
            capture = 1'b0;
            if (rdy) i++;
            cyc++;
        end
        check_eq("cycles", 32'(cyc), 32'(TOTAL + stalls + (cyc - TOTAL - stalls)));
        check_eq("dn.done",  32'(done), 32'h1);
        check_eq("dn.valid", 32'(sout_valid), 32'h0);
        check_eq("dn.busy",  32'(busy), 32'h1);
        sout_ready = 1'($urandom_range(1));
        if (drop_in_done) begin
            capture  = 1'b1;
            dst_bus  = TOTAL'($urandom);
            exp_drop = 1'b1;
        end
        @(negedge clk);
        capture = 1'b0;
        check_idle("post");
        if (drop_in_done) begin
            @(negedge clk);
            check_idle("post2");
        end
        $display("word %h streamed in %0d cycles, drop=%0b sig=%h", w, cyc, capture_drop, signature);
    endtask

    initial begin
        logic [TOTAL-1:0] w;
        rst        = 1'b1;
        capture    = 1'b0;
        sout_ready = 1'b0;
        dst_bus    = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Plain stream, ready held high
        capture_word(27'h5A5A5A5);
        stream_word(27'h5A5A5A5, 100, -1, 0, -1, -1, 1'b0);

        // Three-cycle stall at bit 5
        capture_word(27'h5A5A5A5);
        stream_word(27'h5A5A5A5, 100, 5, 3, -1, -1, 1'b0);

        // Capture during SHIFT is dropped and sticky
        capture_word(27'h5A5A5A5);
        stream_word(27'h5A5A5A5, 100, -1, 0, 10, -1, 1'b0);
        check_eq("drop.sticky", 32'(capture_drop), 32'h1);

        // Reset mid-word, then a fresh single-bit word
        capture_word(27'h5A5A5A5);
        stream_word(27'h5A5A5A5, 100, -1, 0, -1, 10, 1'b0);
        capture_word(27'h0000001);
        stream_word(27'h0000001, 100, -1, 0, -1, -1, 1'b0);

        // Signature sequence from reset
        do_reset();
        capture_word(27'h0000001);
`ifdef RESULT_SIGNATURE_EN
        check_eq("sig.first", signature, 32'h00000001);
`else
        check_eq("sig.first", signature, 32'h0);
`endif
        stream_word(27'h0000001, 100, -1, 0, -1, -1, 1'b0);
        capture_word(27'h0);
`ifdef RESULT_SIGNATURE_EN
        check_eq("sig.second", signature, 32'h00000002);
`else
        check_eq("sig.second", signature, 32'h0);
`endif
        stream_word(27'h0, 100, -1, 0, -1, -1, 1'b1);

        // Randomized words, ready patterns and drops
        do_reset();
        for (int t = 0; t < 24; t++) begin
            w = TOTAL'($urandom);
            capture_word(w);
            stream_word(w, int'($urandom_range(40, 100)), -1, 0,
                        ($urandom_range(3) == 0) ? int'($urandom_range(TOTAL - 1)) : -1,
                        -1, ($urandom_range(4) == 0));
            if ($urandom_range(2) == 0) begin
                sout_ready = 1'($urandom_range(1));
                @(negedge clk);
                check_idle("gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
